// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if
// -----------------
// Bundles the job-request, result and status signals of shift_seq_ctrl.
//
// Handshake rules, the same on both channels:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   - Request channel: in_valid_i / in_ready_o, with dir_i, amt_i and data_i
//     as payload. The payload only matters on the transfer edge.
//   - Result channel: out_valid_o / out_ready_i, with result_o as payload.
//     While out_valid_o is 1, result_o stays stable until the transfer edge.
//     While out_valid_o is 0, result_o is 0.
//   ready is never a function of valid, so there is no combinational loop.
//
// Modports:
//   master - the requester/consumer side. Drives the job and out_ready_i.
//   slave  - the shift sequencer itself.
interface shift_seq_ctrl_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        dir_i;
    logic [3:0]  amt_i;
    logic [15:0] data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
    logic        busy_o;

    modport master (
        output in_valid_i, dir_i, amt_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, busy_o
    );

    modport slave (
        input  in_valid_i, dir_i, amt_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// --------------
// Sequences a 16-bit logical shift one bit per clock.
// A job is a direction, a distance of 0..15 and an operand. The block accepts
// one job. It then shifts the latched operand once per cycle for amt cycles.
// It presents the result until the consumer takes it, and only then becomes
// ready for the next job.
//
// Ports:
//   clk_i    - single clock. All state updates on the rising edge.
//   rst_i    - asynchronous, active-low reset.
//   bus      - shift_seq_ctrl_if.slave. It carries the request channel
//              (in_valid_i/in_ready_o, dir_i, amt_i, data_i), the result
//              channel (out_valid_o/out_ready_i, result_o) and busy_o.
//   state_o  - current FSM state, for debug and checkers
//              (0 = IDLE, 1 = SHIFT, 2 = DONE).
module shift_seq_ctrl (
    input  logic                   clk_i,
    input  logic                   rst_i,
    shift_seq_ctrl_if.slave        bus,
    output logic [1:0]             state_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state_q;
    logic [15:0] data_q;
    logic        dir_q;   // 0 = right, 1 = left
    logic [3:0]  cnt_q;   // shifts still to do

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            data_q  <= 16'h0000;
            dir_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready_o is 1 here, so in_valid_i alone means an accept.
                    if (bus.in_valid_i) begin
                        data_q  <= bus.data_i;
                        dir_q   <= bus.dir_i;
                        cnt_q   <= bus.amt_i;
                        state_q <= (bus.amt_i != 4'd0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (dir_q)
                        data_q <= {data_q[14:0], 1'b0};
                    else
                        data_q <= {1'b0, data_q[15:1]};
                    cnt_q <= cnt_q - 4'd1;
                    // This edge does the last shift, so the result is ready
                    // in the following cycle.
                    if (cnt_q == 4'd1)
                        state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready_i)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.result_o    = (state_q == DONE) ? data_q : 16'h0000;
    assign bus.busy_o      = (state_q != IDLE);
    assign state_o         = state_q;

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 16 bits and the shift amount at 4 bits.
REQ-002 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 in_valid_i  input  1  requester has a shift job on dir_i/amt_i/data_i.
REQ-005 in_ready_o  output  1  block can accept a job this cycle.
REQ-006 dir_i  input  1  0 = logical shift right, 1 = logical shift left.
REQ-007 amt_i  input  4  shift distance, 0..15.
REQ-008 data_i  input  16  operand.
REQ-009 out_valid_o  output  1  result_o holds a finished result.
REQ-010 out_ready_i  input  1  consumer takes the result this cycle.
REQ-011 result_o  output  16  shifted result.
REQ-012 busy_o  output  1  job in progress or result awaiting pickup.

Function
REQ-013 The block SHALL sequence a 1-bit-per-cycle 16-bit shift datapath: right shift gives r[i]=d[i+1] with r[15]=0, and left shift gives r[i]=d[i-1] with r[0]=0.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 In IDLE, in_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-016 A job SHALL be accepted on an edge where in_valid_i and in_ready_o are both 1; on that edge data_i, dir_i and amt_i SHALL be latched into internal data, direction and count registers.
REQ-017 On acceptance, the next state SHALL be SHIFT if amt_i is nonzero, else DONE.
REQ-018 In SHIFT, each edge SHALL replace the data register with its 1-bit shift in the latched direction and decrement the count; on the edge where count equals 1, the next state SHALL be DONE.
REQ-019 SHIFT SHALL last exactly amt cycles, so that for a job accepted on edge k, out_valid_o is first high in the cycle after edge k+amt.
REQ-020 In DONE, out_valid_o SHALL be 1 and result_o SHALL equal the data register, held stable until out_ready_i is 1.
REQ-021 On an edge in DONE with out_ready_i=1, the next state SHALL be IDLE; there SHALL be no result-to-accept bypass, giving a minimum job spacing of amt+2 cycles.
REQ-022 While out_valid_o is 0, result_o SHALL be 0.
REQ-023 busy_o SHALL be 1 exactly when the state is not IDLE.
REQ-024 Changes on dir_i, amt_i, data_i or in_valid_i outside an accept edge SHALL have no effect on the job in progress.
REQ-025 out_ready_i asserted outside DONE SHALL be ignored.
REQ-026 Bits shifted out SHALL be discarded with zero fill; amt=15 SHALL leave at most one original bit.

Reset
REQ-027 While rst_i=0, the state SHALL be IDLE and the data, direction and count registers SHALL be 0, independent of clk_i.
REQ-028 During reset, outputs SHALL be in_ready_o=1, out_valid_o=0, result_o=16'h0000 and busy_o=0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the job immediately; no result SHALL be presented after release.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_i deasserts.

Verification
REQ-031 Right shift: accept data=16'hF00F, dir=0, amt=4 -> out_valid_o first high 4 cycles after the accept edge, with result_o=16'h0F00.
REQ-032 Left shift and zero shift:
- data=16'hFFFF, dir=1, amt=15 -> result_o=16'h8000.
- data=16'h1234, amt=0 -> result_o=16'h1234 in the cycle after the accept edge.
REQ-033 Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> result_o and out_valid_o stable, in_ready_o=0, busy_o=1; release -> IDLE next cycle.
REQ-034 Input changes mid-job: hold in_valid_i=1 and toggle data_i/amt_i during SHIFT -> the current result is unaffected and the next job is accepted only after the DONE handshake.
REQ-035 Mid-job reset: pulse rst_i low in SHIFT, asynchronous to clk_i -> outputs go to their reset values immediately; no out_valid_o after release; a fresh job then completes correctly.
